// File: rtl/vec_act_sched.sv
// Round-robin scheduler sharing one leaky-ReLU chunk datapath between NumReq layer FIFOs; vector-granular grants.
// Latency: request seen in IDLE -> first pop next cycle -> registered chunk the cycle after; one idle bubble per vector.
// Backpressure: out_valid && !out_ready holds the output register and pops nothing. Define SCHED_FIXED_PRIORITY_EN for lowest-index priority.
module vec_act_sched #(
    parameter int NumReq      = 4,
    parameter int InVecLength = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 8,
    localparam int ChunkW     = WorkingRegs * NBits,
    localparam int SrcW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NumReq-1:0]              req_valid,
    input  logic [NumReq-1:0][ChunkW-1:0]  req_data,
    output logic [NumReq-1:0]              req_pop,
    output logic [ChunkW-1:0]              act_in_data,
    input  logic [ChunkW-1:0]              act_out_data,
    output logic [ChunkW-1:0]              out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SrcW-1:0]                out_src,
    output logic                           out_last,
    output logic                           busy
);

    localparam int C    = (InVecLength + WorkingRegs - 1) / WorkingRegs;
    localparam int CntW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_q, state_d;
    logic [SrcW-1:0]   grant_q, grant_d;
    logic [SrcW-1:0]   rr_q, rr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [SrcW-1:0]   pick;
    logic [SrcW:0]     idx;
    logic              found;
    logic              fire;
    logic              last_chunk;

    // Search starts at the rotating pointer; the fixed-priority build pins it at 0,
    // which turns the same search into lowest-index-first.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = {1'b0, rr_q} + (SrcW+1)'(k);
            if (idx >= (SrcW+1)'(NumReq)) begin
                idx = idx - (SrcW+1)'(NumReq);
            end
            if (!found && req_valid[idx[SrcW-1:0]]) begin
                found = 1'b1;
                pick  = idx[SrcW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        req_pop     = '0;
        act_in_data = '0;
        fire        = 1'b0;
        last_chunk  = (cnt_q == CntW'(C - 1));
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                act_in_data = req_data[grant_q];
                // Pops are gated by reset so a chunk is never lost in the reset cycle.
                fire = req_valid[grant_q] && (!out_valid || out_ready) && !rst_in;
                if (fire) begin
                    req_pop[grant_q] = 1'b1;
                    cnt_d            = cnt_q + CntW'(1);
                    if (last_chunk) begin
                        state_d = IDLE;
`ifndef SCHED_FIXED_PRIORITY_EN
                        rr_d = (grant_q == SrcW'(NumReq - 1)) ? '0 : grant_q + SrcW'(1);
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            if (fire) begin
                out_data  <= act_out_data;
                out_src   <= grant_q;
                out_last  <= last_chunk;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q == STREAM);

endmodule

// File: tb/tb_vec_act_sched.sv
// Scoreboard bench for vec_act_sched: requester FIFO models, leaky-ReLU datapath model, per-source expected queues.
module tb_vec_act_sched;

    localparam int NumReq      = 4;
    localparam int WorkingRegs = 4;
    localparam int NBits       = 8;
    localparam int C           = 4;
    localparam int ChunkW      = WorkingRegs * NBits;
    localparam int SrcW        = 2;

    logic                          clk_in = 1'b0;
    logic                          rst_in;
    logic [NumReq-1:0]             req_valid;
    logic [NumReq-1:0][ChunkW-1:0] req_data;
    logic [NumReq-1:0]             req_pop;
    logic [ChunkW-1:0]             act_in_data;
    logic [ChunkW-1:0]             act_out_data;
    logic [ChunkW-1:0]             out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [SrcW-1:0]               out_src;
    logic                          out_last;
    logic                          busy;

    always #5 clk_in = ~clk_in;

    vec_act_sched #(
        .NumReq(NumReq), .InVecLength(16), .WorkingRegs(WorkingRegs), .NBits(NBits)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid(req_valid), .req_data(req_data), .req_pop(req_pop),
        .act_in_data(act_in_data), .act_out_data(act_out_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src), .out_last(out_last), .busy(busy)
    );

    function automatic logic [ChunkW-1:0] leaky(input logic [ChunkW-1:0] x);
        logic [ChunkW-1:0]       y;
        logic signed [NBits-1:0] e;
        y = '0;
        for (int j = 0; j < WorkingRegs; j++) begin
            e = x[j*NBits +: NBits];
            y[j*NBits +: NBits] = e[NBits-1] ? (e >>> 7) : e;
        end
        return y;
    endfunction

    always_comb act_out_data = leaky(act_in_data);

    // Requester FIFO models, owned by the single stimulus thread.
    logic [ChunkW-1:0] mem [NumReq][128];
    logic [6:0]        wr_ptr [NumReq];
    logic [6:0]        rd_ptr [NumReq];
    logic [NumReq-1:0] req_en;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            req_valid[i] = (rd_ptr[i] < wr_ptr[i]) && req_en[i];
            req_data[i]  = mem[i][rd_ptr[i]];
        end
    end

    typedef struct packed {
        logic [ChunkW-1:0] dat;
        logic              last;
    } exp_t;

    exp_t exp_q [NumReq][$];
    int   push_pos [NumReq];
    int   vec_order [$];
    int   done_step [$];
    int   step_cnt;
    int   hs_cnt;
    int   total;
    int   bad;

    task automatic push_chunk(input int r, input logic [ChunkW-1:0] dat);
        exp_t e;
        mem[r][wr_ptr[r]] = dat;
        wr_ptr[r] = wr_ptr[r] + 7'd1;
        e.dat  = leaky(dat);
        e.last = (push_pos[r] == C - 1);
        exp_q[r].push_back(e);
        push_pos[r] = (push_pos[r] + 1) % C;
    endtask

    task automatic push_vec(input int r);
        for (int k = 0; k < C; k++) push_chunk(r, $urandom());
    endtask

    task automatic flush(input int r);
        rd_ptr[r] = wr_ptr[r];
        exp_q[r].delete();
        push_pos[r] = 0;
    endtask

    // One clock: sample before the edge, advance FIFOs and score handshakes after it.
    task automatic step();
        logic [NumReq-1:0] pop_s;
        logic              hs;
        logic [ChunkW-1:0] d;
        logic [SrcW-1:0]   s;
        logic              l;
        logic              rst_s;
        exp_t              e;
        #3;
        pop_s = req_pop;
        hs    = out_valid && out_ready;
        d     = out_data;
        s     = out_src;
        l     = out_last;
        rst_s = rst_in;
        @(posedge clk_in);
        #1;
        step_cnt++;
        for (int i = 0; i < NumReq; i++) if (pop_s[i]) rd_ptr[i] = rd_ptr[i] + 7'd1;
        total++;
        if ($countones(pop_s) > 1) begin
            bad++;
            $display("FAIL pop_onehot got=%b exp=at most one bit", pop_s);
        end
        if (hs && !rst_s) begin
            hs_cnt++;
            total++;
            if (exp_q[s].size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected src=%0d got=%h exp=no chunk", s, d);
            end else begin
                e = exp_q[s].pop_front();
                if ({d, l} !== {e.dat, e.last}) begin
                    bad++;
                    $display("FAIL sb_data src=%0d got=%h/%b exp=%h/%b", s, d, l, e.dat, e.last);
                end
            end
            if (l) begin
                vec_order.push_back(int'(s));
                done_step.push_back(step_cnt);
            end
        end
    endtask

    task automatic drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
                exp_q[3].size() == 0 && !busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step();
        step();
        total++;
        if ({out_valid, out_last, busy, req_pop, out_src} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b%b%b %b %0d exp=all zero", out_valid, out_last, busy, req_pop, out_src);
        end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        total++;
        if (act_in_data !== '0) begin bad++; $display("FAIL reset_act_in got=%h exp=0", act_in_data); end
        rst_in = 1'b0;
        step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        bit ok;
        push_chunk(0, 32'h7F80_05FD);
        for (int k = 1; k < C; k++) push_chunk(0, $urandom());
        #1;
        total++;
        if (req_pop !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle_nopop got=%b/%b exp=0000/0", req_pop, busy);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (req_pop !== ((k < 4) ? 4'b0001 : 4'b0000)) begin
                bad++; $display("FAIL single_pop k=%0d got=%b", k, req_pop);
            end
            total++;
            if (out_valid !== (k >= 1 && k <= 4) || busy !== (k < 4)) begin
                bad++; $display("FAIL single_valid_busy k=%0d got=%b/%b", k, out_valid, busy);
            end
            total++;
            if (out_valid && (out_last !== (k == 4) || out_src !== 2'd0)) begin
                bad++; $display("FAIL single_last_src k=%0d got=%b/%0d", k, out_last, out_src);
            end
            if (k == 1) begin
                total++;
                if (out_data !== 32'h7FFF_05FF) begin
                    bad++; $display("FAIL single_leak got=%h exp=7fff05ff", out_data);
                end
            end
        end
        drain(20, ok);
        total++;
        if (!ok || vec_order.size() == 0 || vec_order[vec_order.size()-1] != 0) begin
            bad++; $display("FAIL single_done ok=%0d exp vector from 0", ok);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        push_vec(1);
        step(); step(); step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (req_pop !== 4'b0000 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold k=%0d got pop=%b vld=%b exp 0000/1", k, req_pop, out_valid);
            end
            total++;
            if (out_data !== exp_q[1][0].dat || out_src !== 2'd1 || out_last !== exp_q[1][0].last) begin
                bad++; $display("FAIL bp_stable k=%0d got=%h exp=%h", k, out_data, exp_q[1][0].dat);
            end
            step();
        end
        out_ready = 1'b1;
        drain(30, ok);
        total++;
        if (!ok || vec_order[vec_order.size()-1] != 1) begin
            bad++; $display("FAIL bp_complete ok=%0d exp vector from 1", ok);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int n;
        n = vec_order.size();
        push_vec(2);
        push_vec(3);
        step(); step(); step();
        req_en[2] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (req_pop !== 4'b0000 || busy !== 1'b1) begin
                bad++; $display("FAIL stall_hold k=%0d got pop=%b busy=%b exp 0000/1", k, req_pop, busy);
            end
            step();
        end
        req_en[2] = 1'b1;
        drain(40, ok);
        total++;
        if (!ok || vec_order.size() != n + 2 || vec_order[n] != 2 || vec_order[n+1] != 3) begin
            bad++; $display("FAIL stall_order ok=%0d count=%0d exp order 2,3", ok, vec_order.size() - n);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int n;
        int exp_src;
        n = vec_order.size();
        for (int r = 0; r < NumReq; r++) begin
            push_vec(r);
            push_vec(r);
        end
        drain(100, ok);
        total++;
        if (!ok || vec_order.size() != n + 8) begin
            bad++; $display("FAIL rr_drain ok=%0d vectors=%0d exp=8", ok, vec_order.size() - n);
        end else begin
            for (int i = 0; i < 8; i++) begin
`ifdef SCHED_FIXED_PRIORITY_EN
                exp_src = i / 2;
`else
                exp_src = i % NumReq;
`endif
                total++;
                if (vec_order[n+i] != exp_src) begin
                    bad++; $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, vec_order[n+i], exp_src);
                end
                if (i > 0) begin
                    total++;
                    if (done_step[n+i] - done_step[n+i-1] != C + 1) begin
                        bad++; $display("FAIL rr_gap i=%0d got=%0d exp=%0d", i, done_step[n+i] - done_step[n+i-1], C + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        int n;
        push_vec(1);
        drain(30, ok);
        push_vec(2);
        base = hs_cnt;
        for (int i = 0; i < 20 && hs_cnt < base + 2; i++) step();
        total++;
        if (hs_cnt < base + 2) begin bad++; $display("FAIL rstmid_timeout got=%0d exp=2 chunks", hs_cnt - base); end
        rst_in = 1'b1;
        step();
        total++;
        if ({out_valid, out_last, busy, req_pop, out_src} !== '0 || out_data !== '0) begin
            bad++; $display("FAIL rstmid_outputs got vld=%b last=%b busy=%b pop=%b src=%0d data=%h exp=all zero",
                            out_valid, out_last, busy, req_pop, out_src, out_data);
        end
        rst_in = 1'b0;
        flush(2);
        n = vec_order.size();
        push_vec(2);
        push_vec(0);
        step();
        total++;
        if (req_pop !== 4'b0001) begin bad++; $display("FAIL rstmid_regrant got=%b exp=0001", req_pop); end
        drain(40, ok);
        total++;
        if (!ok || vec_order.size() != n + 2 || vec_order[n] != 0 || vec_order[n+1] != 2) begin
            bad++; $display("FAIL rstmid_order ok=%0d count=%0d exp order 0,2", ok, vec_order.size() - n);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        step_cnt  = 0;
        hs_cnt    = 0;
        rst_in    = 1'b1;
        out_ready = 1'b1;
        req_en    = '1;
        for (int i = 0; i < NumReq; i++) begin
            wr_ptr[i]   = '0;
            rd_ptr[i]   = '0;
            push_pos[i] = 0;
            for (int j = 0; j < 128; j++) mem[i][j] = '0;
        end
        test_reset();
        test_single();
        test_backpressure();
        test_stall();
        test_round_robin();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_act_sched.md
# vec_act_sched

Round-robin scheduler that shares one combinational elementwise activation datapath (the leaky-ReLU chunk unit) between several layer FIFOs. It grants one requester at a time for a whole vector, pops that requester's chunks into the activation unit, and registers the activated chunks into a single valid/ready output stream tagged with the source ID. It sits between the per-layer output FIFOs of the MLP pipeline and the shared activation stage.

## Interface
- NumReq, 4, number of requesting FIFOs (≥2)
- InVecLength, 16, elements per vector
- WorkingRegs, 4, elements per chunk; chunks per vector C = ceil(InVecLength/WorkingRegs)
- NBits, 8, signed element width
- clk_in  in  1  single clock, all logic on rising edge
- rst_in  in  1  reset, synchronous, active-high
- req_valid  in  NumReq  requester i has a chunk available (FIFO non-empty)
- req_data  in  NumReq×WorkingRegs×NBits  head chunk of each requester FIFO
- req_pop  out  NumReq  one-hot read strobe, combinational, at most one bit high
- act_in_data  out  WorkingRegs×NBits  chunk driven to activation datapath (mux of req_data by grant)
- act_out_data  in  WorkingRegs×NBits  activated chunk returned combinationally by datapath
- out_data  out  WorkingRegs×NBits  registered activated chunk
- out_valid  out  1  out_data holds a chunk
- out_ready  in  1  downstream accepts out_data this cycle
- out_src  out  clog2(NumReq)  requester index of out_data
- out_last  out  1  out_data is chunk C-1 of its vector
- busy  out  1  high in STREAM state

## Operation
- States: IDLE, STREAM.
- IDLE: if any req_valid, pick grant (see Configuration), load grant register, clear chunk counter, go to STREAM. No pop in IDLE.
- STREAM: transfer fires when req_valid[grant] && (!out_valid || out_ready). On fire: req_pop[grant]=1; out_data<=act_out_data, out_src<=grant, out_last<=(cnt==C-1), out_valid<=1; cnt++.
- On fire with cnt==C-1: round-robin pointer <= grant+1 (mod NumReq); state -> IDLE.
- out_valid cleared when out_ready && out_valid and no fire that cycle.
- Grant held for the full vector; req_valid[grant] low mid-vector stalls (no pop, no timeout); other requesters ignored.
- act_in_data = req_data[grant] at all times in STREAM; zero in IDLE.
- Out-of-range grant never produced; requesters with req_valid low never granted.
- Partial last chunk (InVecLength not a multiple of WorkingRegs): still one full chunk; unused lanes passed through unchanged.

## Timing
- Reset values: req_pop=0, out_valid=0, out_data=0, out_src=0, out_last=0, busy=0, state=IDLE, rr pointer=0, cnt=0.
- Reset mid-vector: partial vector abandoned, output register cleared; the requester FIFO keeps unpopped chunks.
- Latency: req_valid seen in IDLE at cycle t → busy and first req_pop at t+1 → out_valid at t+2.
- Full throughput: one chunk per cycle while out_ready=1 and req_valid[grant]=1.
- One IDLE bubble between consecutive vectors (arbitration cycle).
- out_valid && !out_ready: out_data, out_src, out_last stable; no pop.
- Simultaneous out_ready and fire: register replaced same edge, out_valid stays 1.

## Configuration
- SCHED_FIXED_PRIORITY_EN defined: grant = lowest index with req_valid set; rr pointer unused (held at 0).
- Undefined (default): round-robin, search starts at rr pointer, wraps at NumReq-1→0.

## Test plan
- Single requester 0, C=4, out_ready=1 → req_pop[0] high 4 consecutive cycles, out_valid for 4 cycles, out_src=0, out_last only on 4th chunk, busy low afterward.
- All 4 requesters valid continuously, round-robin → vector grant order 0,1,2,3,0; one-cycle IDLE gap between vectors; FIXED_PRIORITY build → 0 every time.
- Chunk containing -128 and 127 → out_data shows -1 and 127 (datapath >>7 leak), proving act_out_data is captured, not req_data.
- out_ready low for 3 cycles mid-vector → out_data stable, no req_pop, resumes with no lost or duplicated chunk.
- req_valid[grant] drops for 2 cycles mid-vector while requester 1 valid → stall, grant not switched, vector completes with 4 chunks.
- rst_in asserted after chunk 2 → next cycle all outputs at reset values; re-arbitration starts at requester 0.
